// File: rtl/scene_compositor.sv
// scene_compositor: N-layer priority compositor, scene sequencer and
// background scroll counter.
//
// Ports:
//   clk               system clock
//   clr               asynchronous active-low reset
//   video_on          active-video flag, aligned with the layer inputs
//   layer_rgb         packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   layer_on          per-layer pixel-valid flags
//   user_mask         runtime layer enables, ANDed with the scene mask
//   game_over         level from the game engine
//   skip              pulse, leaves SPLASH early
//   restart           pulse, returns from OVER to SPLASH
//   scroll_tick       slow square wave, each rising edge advances the scroll
//   rgb               composited pixel (2-cycle latency)
//   pix_valid         delayed video_on AND some layer won
//   scene             0=SPLASH 1=PLAY 2=OVER_WAIT 3=OVER
//   game_begin        scene != SPLASH
//   game_over_display scene == OVER
//   scroll_offset     cloud scroll position

// One lane per layer: decides whether the layer may win this pixel.
module scene_compositor_lane #(
  parameter int                 COLOR_W   = 12,
  parameter int                 KEY_EN    = 1,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic [COLOR_W-1:0] color,
  input  logic               on,
  input  logic               en,
  output logic               cand
);
  logic keyed;
  assign keyed = (KEY_EN != 0) && (color == KEY_COLOR);
  assign cand  = on & en & ~keyed;
endmodule

module scene_compositor #(
  parameter int                 LAYERS            = 4,
  parameter int                 COLOR_W           = 12,
  parameter int                 TIMER_W           = 32,
  parameter int                 SPLASH_CYCLES     = 500_000_000,
  parameter int                 OVER_DELAY_CYCLES = 5_000,
  parameter int                 KEY_EN            = 1,
  parameter logic [COLOR_W-1:0] KEY_COLOR         = 12'hF0F,
  parameter logic [LAYERS-1:0]  MASK_PLAY         = 4'b1111,
  parameter logic [LAYERS-1:0]  MASK_STATIC       = 4'b0010,
  parameter int                 SCROLL_W          = 10,
  parameter int                 SCROLL_MAX        = 639
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      video_on,
  input  logic [LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [LAYERS-1:0]         layer_on,
  input  logic [LAYERS-1:0]         user_mask,
  input  logic                      game_over,
  input  logic                      skip,
  input  logic                      restart,
  input  logic                      scroll_tick,
  output logic [COLOR_W-1:0]        rgb,
  output logic                      pix_valid,
  output logic [1:0]                scene,
  output logic                      game_begin,
  output logic                      game_over_display,
  output logic [SCROLL_W-1:0]       scroll_offset
);
  typedef enum logic [1:0] {SPLASH = 2'd0, PLAY = 2'd1, OVER_WAIT = 2'd2, OVER = 2'd3} scene_t;

  localparam logic [TIMER_W-1:0]  SPLASH_LAST = TIMER_W'(SPLASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  OVER_LAST   = TIMER_W'(OVER_DELAY_CYCLES - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_MAX);

  // ---------------- scene FSM ----------------
  scene_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= SPLASH;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Every transition zeroes the timer; it only counts in the two timed
  // scenes and stops at the terminal value, so it can never wrap.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      SPLASH: begin
        if (skip || timer_q == SPLASH_LAST) begin
          state_d = PLAY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      PLAY: begin
        timer_d = '0;
        if (game_over) state_d = OVER_WAIT;
      end
      OVER_WAIT: begin
        if (timer_q == OVER_LAST) begin
          state_d = OVER;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      OVER: begin
        timer_d = '0;
        if (restart) state_d = SPLASH;
      end
      default: begin
        state_d = SPLASH;
        timer_d = '0;
      end
    endcase
  end

  assign scene             = state_q;
  assign game_begin        = (state_q != SPLASH);
  assign game_over_display = (state_q == OVER);

  // ---------------- compositor ----------------
  logic [LAYERS-1:0][COLOR_W-1:0] lay;
  logic [LAYERS-1:0]              eff_mask;
  logic [LAYERS-1:0]              cand;
  logic [COLOR_W-1:0]             win;

  assign lay      = layer_rgb;
  assign eff_mask = user_mask & ((state_q == PLAY) ? MASK_PLAY : MASK_STATIC);

  for (genvar i = 0; i < LAYERS; i++) begin : g_lane
    scene_compositor_lane #(
      .COLOR_W  (COLOR_W),
      .KEY_EN   (KEY_EN),
      .KEY_COLOR(KEY_COLOR)
    ) u_lane (
      .color(lay[i]),
      .on   (layer_on[i]),
      .en   (eff_mask[i]),
      .cand (cand[i])
    );
  end

  // Ascending scan: the last candidate seen is the highest-priority one.
  always_comb begin
    win = '0;
    for (int i = 0; i < LAYERS; i++)
      if (cand[i]) win = lay[i];
  end

  // vld_pipe[1]: video_on at stage 1; vld_pipe[2]: pix_valid at stage 2.
  logic [2:1]         vld_pipe;
  logic               hit_q;
  logic [COLOR_W-1:0] color_q;
  logic [COLOR_W-1:0] rgb_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vld_pipe <= '0;
      hit_q    <= 1'b0;
      color_q  <= '0;
      rgb_q    <= '0;
    end else begin
      vld_pipe[1] <= video_on;
      hit_q       <= |cand;
      color_q     <= win;
      vld_pipe[2] <= hit_q & vld_pipe[1];
      rgb_q       <= (hit_q & vld_pipe[1]) ? color_q : '0;
    end
  end

  assign rgb       = rgb_q;
  assign pix_valid = vld_pipe[2];

  // ---------------- scroll ----------------
  logic                tick_q;
  logic                tick_rise;
  logic [SCROLL_W-1:0] scroll_q;

  assign tick_rise = scroll_tick & ~tick_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tick_q   <= 1'b0;
      scroll_q <= '0;
    end else begin
      tick_q <= scroll_tick;
      if (tick_rise && (state_q == SPLASH || state_q == PLAY))
        scroll_q <= (scroll_q == SCROLL_LAST) ? '0 : scroll_q + SCROLL_W'(1);
    end
  end

  assign scroll_offset = scroll_q;
endmodule

// File: tb/tb_scene_compositor.sv
// tb_scene_compositor: directed, table-driven bench for scene_compositor
// with short scene timers and a small scroll range.
module tb_scene_compositor;
  logic        clk = 1'b0;
  logic        clr;
  logic        video_on;
  logic [47:0] layer_rgb;
  logic [3:0]  layer_on;
  logic [3:0]  user_mask;
  logic        game_over, skip, restart, scroll_tick;
  logic [11:0] rgb;
  logic        pix_valid;
  logic [1:0]  scene;
  logic        game_begin, game_over_display;
  logic [9:0]  scroll_offset;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scene_compositor #(
    .SPLASH_CYCLES    (10),
    .OVER_DELAY_CYCLES(4),
    .SCROLL_MAX       (3)
  ) dut (
    .clk              (clk),
    .clr              (clr),
    .video_on         (video_on),
    .layer_rgb        (layer_rgb),
    .layer_on         (layer_on),
    .user_mask        (user_mask),
    .game_over        (game_over),
    .skip             (skip),
    .restart          (restart),
    .scroll_tick      (scroll_tick),
    .rgb              (rgb),
    .pix_valid        (pix_valid),
    .scene            (scene),
    .game_begin       (game_begin),
    .game_over_display(game_over_display),
    .scroll_offset    (scroll_offset)
  );

  typedef struct {
    logic        vo;
    logic [3:0]  on;
    logic [3:0]  mask;
    logic [11:0] c0, c1, c2, c3;
    logic [11:0] exp_rgb;
    logic        exp_pv;
  } vec_t;

  vec_t tbl [0:12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_pix(input logic vo, input logic [3:0] on, input logic [3:0] mask,
                           input logic [11:0] c0, input logic [11:0] c1,
                           input logic [11:0] c2, input logic [11:0] c3);
    video_on  = vo;
    layer_on  = on;
    user_mask = mask;
    layer_rgb = {c3, c2, c1, c0};
  endtask

  task automatic apply_vec(input int i);
    drive_pix(tbl[i].vo, tbl[i].on, tbl[i].mask, tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
    tick();
    tick();
    check($sformatf("vec%0d rgb", i), 32'(rgb), 32'(tbl[i].exp_rgb));
    check($sformatf("vec%0d pix_valid", i), 32'(pix_valid), 32'(tbl[i].exp_pv));
  endtask

  initial begin
    int exp_scroll [5];
    exp_scroll = '{1, 2, 3, 0, 1};

    // PLAY scene (MASK_PLAY = 1111, key = F0F)
    tbl[0]  = '{1'b1, 4'b1011, 4'hF, 12'h111, 12'h0A0, 12'h333, 12'hF0F, 12'h0A0, 1'b1};
    tbl[1]  = '{1'b1, 4'b1011, 4'hF, 12'h111, 12'h0A0, 12'h333, 12'h123, 12'h123, 1'b1};
    tbl[2]  = '{1'b0, 4'b1011, 4'hF, 12'h111, 12'h0A0, 12'h333, 12'h123, 12'h000, 1'b0};
    tbl[3]  = '{1'b1, 4'b1011, 4'h0, 12'h111, 12'h0A0, 12'h333, 12'h123, 12'h000, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 4'hF, 12'h111, 12'h0A0, 12'h333, 12'h123, 12'h000, 1'b0};
    tbl[5]  = '{1'b1, 4'b1111, 4'h7, 12'h111, 12'h0A0, 12'h456, 12'h123, 12'h456, 1'b1};
    tbl[6]  = '{1'b1, 4'b0001, 4'hF, 12'hF0F, 12'h0A0, 12'h456, 12'h123, 12'h000, 1'b0};
    tbl[7]  = '{1'b1, 4'b0001, 4'hF, 12'hABC, 12'h0A0, 12'h456, 12'h123, 12'hABC, 1'b1};
    tbl[8]  = '{1'b1, 4'b1111, 4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1};
    // OVER scene (MASK_STATIC = 0010)
    tbl[9]  = '{1'b1, 4'b1111, 4'hF, 12'h111, 12'h222, 12'h333, 12'h444, 12'h222, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, 4'hF, 12'h111, 12'h222, 12'h333, 12'h444, 12'h000, 1'b0};
    tbl[11] = '{1'b1, 4'b1111, 4'h0, 12'h111, 12'h222, 12'h333, 12'h444, 12'h000, 1'b0};
    tbl[12] = '{1'b1, 4'b1101, 4'hF, 12'h111, 12'h222, 12'h333, 12'h444, 12'h000, 1'b0};

    clr = 1'b0;
    drive_pix(1'b0, 4'h0, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    game_over = 1'b0; skip = 1'b0; restart = 1'b0; scroll_tick = 1'b0;
    #2;
    check("reset scene", 32'(scene), 0);
    check("reset rgb", 32'(rgb), 0);
    check("reset pix_valid", 32'(pix_valid), 0);
    check("reset scroll", 32'(scroll_offset), 0);
    check("reset game_begin", 32'(game_begin), 0);
    check("reset over_display", 32'(game_over_display), 0);

    // Splash auto-advance after exactly 10 cycles.
    tick();
    clr = 1'b1;
    repeat (9) tick();
    check("splash before timeout", 32'(scene), 0);
    tick();
    check("splash timeout scene", 32'(scene), 1);
    check("splash timeout game_begin", 32'(game_begin), 1);

    // Build up non-reset state, then reset between clock edges.
    drive_pix(1'b1, 4'b0010, 4'hF, 12'h0, 12'h0A0, 12'h0, 12'h0);
    scroll_tick = 1'b1;
    tick();
    tick();
    check("pre-reset rgb", 32'(rgb), 32'h0A0);
    check("pre-reset scroll", 32'(scroll_offset), 1);
    scroll_tick = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    check("async reset scene", 32'(scene), 0);
    check("async reset rgb", 32'(rgb), 0);
    check("async reset pix_valid", 32'(pix_valid), 0);
    check("async reset scroll", 32'(scroll_offset), 0);
    check("async reset game_begin", 32'(game_begin), 0);
    drive_pix(1'b0, 4'h0, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    tick();
    clr = 1'b1;

    // Splash skip in cycle 3.
    repeat (3) tick();
    check("before skip", 32'(scene), 0);
    skip = 1'b1;
    tick();
    skip = 1'b0;
    check("skip to play", 32'(scene), 1);
    skip = 1'b1;
    tick();
    skip = 1'b0;
    check("skip in play ignored", 32'(scene), 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart in play ignored", 32'(scene), 1);

    // Scroll wrap with scroll_tick held high 3 cycles per pulse.
    for (int k = 0; k < 5; k++) begin
      scroll_tick = 1'b1;
      tick();
      check($sformatf("scroll edge %0d", k), 32'(scroll_offset), 32'(exp_scroll[k]));
      tick();
      tick();
      check($sformatf("scroll held %0d", k), 32'(scroll_offset), 32'(exp_scroll[k]));
      scroll_tick = 1'b0;
      tick();
    end

    // Compositor vectors in PLAY.
    for (int i = 0; i <= 8; i++) apply_vec(i);

    // Back-to-back stream: each result lands exactly two cycles later.
    drive_pix(1'b0, 4'h0, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0);
    tick(); tick();
    drive_pix(1'b1, 4'b0001, 4'hF, 12'hABC, 12'h0, 12'h0, 12'h0);
    tick();
    check("stream lat1 pix_valid", 32'(pix_valid), 0);
    drive_pix(1'b1, 4'b0000, 4'hF, 12'hABC, 12'h0, 12'h0, 12'h0);
    tick();
    check("stream A rgb", 32'(rgb), 32'hABC);
    check("stream A pix_valid", 32'(pix_valid), 1);
    drive_pix(1'b1, 4'b1000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h123);
    tick();
    check("stream B rgb", 32'(rgb), 0);
    check("stream B pix_valid", 32'(pix_valid), 0);
    tick();
    check("stream C rgb", 32'(rgb), 32'h123);

    // Game over: dropping game_over in OVER_WAIT is ignored.
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("over_wait scene", 32'(scene), 2);
    check("over_wait display", 32'(game_over_display), 0);
    repeat (3) tick();
    check("over_wait held", 32'(scene), 2);
    tick();
    check("over scene", 32'(scene), 3);
    check("over display", 32'(game_over_display), 1);

    // Scroll frozen in OVER.
    scroll_tick = 1'b1;
    tick();
    check("scroll frozen", 32'(scroll_offset), 1);
    scroll_tick = 1'b0;
    tick();

    // Scene masking in OVER.
    for (int i = 9; i <= 12; i++) apply_vec(i);

    skip = 1'b1;
    tick();
    skip = 1'b0;
    check("skip in over ignored", 32'(scene), 3);

    // Restart back to SPLASH; timer starts over.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart scene", 32'(scene), 0);
    check("restart game_begin", 32'(game_begin), 0);
    check("restart display", 32'(game_over_display), 0);
    repeat (9) tick();
    check("restart splash hold", 32'(scene), 0);
    tick();
    check("restart splash timeout", 32'(scene), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
